// File: rtl/lvds_demo_pkg.sv
// Shared definitions for the LVDS loopback pattern checker: FSM encoding, default pattern/OSR and rotate helper.
package lvds_demo_pkg;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } chk_state_e;

  localparam logic [7:0] DEFAULT_PATTERN = 8'b1100_1010;
  localparam int         DEFAULT_OSR     = 5;

  function automatic logic [7:0] rotl8(input logic [7:0] v, input logic [2:0] k);
    logic [15:0] t;
    t = {v, v} << k;
    return t[15:8];
  endfunction

endpackage

// File: rtl/lvds_bit_recovery.sv
// Synchronises the raw LVDS receiver output and recovers one bit per OSR clocks by
// re-centring a phase counter on every data edge.
module lvds_bit_recovery
  import lvds_demo_pkg::*;
#(
  parameter int OSR = DEFAULT_OSR
) (
  input  logic clk_in,
  input  logic reset_n,
  input  logic rx_i,
  output logic bit_valid_o,
  output logic bit_data_o
);

  localparam int              PH_W    = $clog2(OSR);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OSR - 1);
  localparam logic [PH_W-1:0] PH_MID  = PH_W'(OSR / 2);

  logic            rx_s1_q, rx_s_q, rx_d_q;
  logic [PH_W-1:0] phase_q, phase_d;
  logic            bit_valid_q, bit_valid_d;
  logic            bit_data_q, bit_data_d;
  logic            edge_s;

  assign edge_s = rx_s_q ^ rx_d_q;

  // Sample mid-bit, counting from the most recent edge
  always_comb begin
    phase_d     = phase_q;
    bit_valid_d = 1'b0;
    bit_data_d  = bit_data_q;
    if (edge_s) begin
      phase_d = '0;
    end else if (phase_q == PH_LAST) begin
      phase_d = '0;
    end else begin
      phase_d = phase_q + PH_W'(1);
    end
    if (!edge_s && (phase_q == PH_MID)) begin
      bit_valid_d = 1'b1;
      bit_data_d  = rx_s_q;
    end else begin
      bit_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      rx_s1_q     <= 1'b0;
      rx_s_q      <= 1'b0;
      rx_d_q      <= 1'b0;
      phase_q     <= '0;
      bit_valid_q <= 1'b0;
      bit_data_q  <= 1'b0;
    end else begin
      rx_s1_q     <= rx_i;
      rx_s_q      <= rx_s1_q;
      rx_d_q      <= rx_s_q;
      phase_q     <= phase_d;
      bit_valid_q <= bit_valid_d;
      bit_data_q  <= bit_data_d;
    end
  end

  assign bit_valid_o = bit_valid_q;
  assign bit_data_o  = bit_data_q;

endmodule

// File: rtl/lvds_pattern_checker.sv
// Aligns recovered LVDS loopback bits to the rotating pattern and reports lock and bit errors.
// Define LVDS_CHK_ERRCNT_EN to build the saturating err_count counter and clr_errors input.
module lvds_pattern_checker
  import lvds_demo_pkg::*;
#(
  parameter int         OSR         = DEFAULT_OSR,
  parameter logic [7:0] PATTERN     = DEFAULT_PATTERN,
  parameter int         LOSS_THRESH = 4,
  parameter int         ERR_W       = 16
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             rx_in,
  input  logic             clr_errors,
  output logic             bit_valid,
  output logic             bit_data,
  output logic             locked,
  output logic             err_pulse,
  output logic             lock_lost,
  output logic [ERR_W-1:0] err_count
);

  logic             bit_valid_s, bit_data_s;
  chk_state_e       state_q, state_d;
  logic [7:0]       sr_q, sr_d, sr_new_s;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       exp_q, exp_d;
  logic [3:0]       miss_q, miss_d, miss_inc_s;
  logic             hit_s, err_s, lost_s;
  logic             locked_q, err_pulse_q, lock_lost_q;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  lvds_bit_recovery #(.OSR(OSR)) u_rec (
    .clk_in     (clk_in),
    .reset_n    (reset_n),
    .rx_i       (rx_in),
    .bit_valid_o(bit_valid_s),
    .bit_data_o (bit_data_s)
  );

  assign sr_new_s   = {sr_q[6:0], bit_data_s};
  assign miss_inc_s = miss_q + 4'd1;

  // Pattern search over all eight rotations of the reference
  always_comb begin
    hit_s = 1'b0;
    for (int k = 0; k < 8; k++) begin
      hit_s = hit_s | (sr_new_s == rotl8(PATTERN, 3'(k)));
    end
  end

  // Lock FSM, shift register and expected-bit tracking
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    exp_d     = exp_q;
    miss_d    = miss_q;
    err_s     = 1'b0;
    lost_s    = 1'b0;
    if (bit_valid_s) begin
      sr_d      = sr_new_s;
      bit_cnt_d = (bit_cnt_q == 4'd8) ? bit_cnt_q : bit_cnt_q + 4'd1;
      case (state_q)
        ST_HUNT: begin
          // The window repeats every 8 bits, so its oldest bit is the next one due
          if ((bit_cnt_q >= 4'd7) && hit_s) begin
            exp_d   = sr_new_s;
            miss_d  = 4'd0;
            state_d = ST_LOCKED;
          end else begin
            state_d = ST_HUNT;
          end
        end
        ST_LOCKED: begin
          exp_d = rotl8(exp_q, 3'd1);
          if (bit_data_s == exp_q[7]) begin
            miss_d = 4'd0;
          end else begin
            err_s = 1'b1;
            if (miss_inc_s == 4'(LOSS_THRESH)) begin
              state_d   = ST_HUNT;
              lost_s    = 1'b1;
              bit_cnt_d = 4'd0;
              miss_d    = 4'd0;
            end else begin
              miss_d = miss_inc_s;
            end
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end else begin
      sr_d = sr_q;
    end
  end

`ifdef LVDS_CHK_ERRCNT_EN
  // Clear takes priority over a coincident error
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clr_errors) begin
      err_cnt_d = '0;
    end else if (err_s && (err_cnt_q != {ERR_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end
`else
  logic clr_unused_s;
  assign clr_unused_s = clr_errors;
  assign err_cnt_d    = '0;
`endif

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      state_q     <= ST_HUNT;
      sr_q        <= 8'd0;
      bit_cnt_q   <= 4'd0;
      exp_q       <= 8'd0;
      miss_q      <= 4'd0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      lock_lost_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      exp_q       <= exp_d;
      miss_q      <= miss_d;
      locked_q    <= (state_q == ST_LOCKED);
      err_pulse_q <= err_s;
      lock_lost_q <= lost_s;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bit_valid = bit_valid_s;
  assign bit_data  = bit_data_s;
  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign lock_lost = lock_lost_q;
  assign err_count = err_cnt_q;

endmodule
